// File: rtl/uart_boot_loader.sv
// uart_boot_loader
//
// Boot sequencer and RAM write-port arbiter. After reset the CPU is held in reset
// and the loader owns the RAM port. A framed image arriving over the UART is written
// word by word into RAM. After the image is written the CPU is released and the RAM
// port is handed over for good. If no magic byte arrives within BOOT_WAIT cycles, the
// CPU boots from whatever RAM already holds.
//
// Frame: 8'hA5, N_lo, N_hi, 4*N payload bytes (little-endian words), CSUM (sum mod 256
// of the payload bytes).
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   rx_valid       one-cycle strobe, rx_byte is valid
//   rx_byte        received UART byte
//   cpu_mem_*      CPU memory request, forwarded to RAM only once running
//   ram_addr       RAM byte address
//   ram_rstrb      RAM read strobe
//   ram_wdata      RAM write data
//   ram_wmask      RAM byte write mask
//   cpu_resetn     active-low CPU reset (registered)
//   busy           a frame is in progress (LEN0/LEN1/DATA/CSUM)
//   error          sticky load error, cleared by the next magic byte
module uart_boot_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned MAX_WORDS      = 1536,
  parameter int unsigned BOOT_WAIT      = 27_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_700_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic [31:0] cpu_mem_addr,
  input  logic        cpu_mem_rstrb,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wmask,
  output logic [31:0] ram_addr,
  output logic        ram_rstrb,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wmask,
  output logic        cpu_resetn,
  output logic        busy,
  output logic        error
);

  localparam logic [7:0]  Magic    = 8'hA5;
  localparam logic [31:0] BootLast = 32'(BOOT_WAIT - 1);
  localparam logic [31:0] GapLast  = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0] MaxWords = 32'(MAX_WORDS);

  typedef enum logic [2:0] {
    StWaitMagic,
    StLen0,
    StLen1,
    StData,
    StCsum,
    StRun
  } state_e;

  state_e      state_q;
  logic [31:0] boot_cnt_q;
  logic [31:0] gap_cnt_q;
  logic [15:0] n_words_q;
  logic [15:0] word_idx_q;
  logic [1:0]  byte_idx_q;
  logic [7:0]  sum_q;
  logic [31:0] word_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wmask_q;
  logic        cpu_resetn_q;
  logic        error_q;

  logic        in_frame;
  logic        timeout;
  logic [31:0] word_next;
  logic [15:0] n_next;

  assign in_frame  = (state_q == StLen0) || (state_q == StLen1) ||
                     (state_q == StData) || (state_q == StCsum);
  // Idle cycles since the last byte have reached TIMEOUT_CYCLES on this edge.
  assign timeout   = (gap_cnt_q == GapLast);
  // First byte of a word ends up in [7:0] after four shifts.
  assign word_next = {rx_byte, word_q[31:8]};
  assign n_next    = {rx_byte, n_words_q[7:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StWaitMagic;
      boot_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      n_words_q    <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      sum_q        <= '0;
      word_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wmask_q      <= '0;
      cpu_resetn_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse.
      wmask_q      <= 4'b0000;
      // Released one cycle after RUN is entered.
      cpu_resetn_q <= (state_q == StRun);

      if (rx_valid) begin
        gap_cnt_q <= '0;
      end else if (!timeout) begin
        gap_cnt_q <= gap_cnt_q + 32'd1;
      end

      if (in_frame && timeout) begin
        // Timeout beats a byte arriving on the same edge; partial image stays in RAM.
        error_q <= 1'b1;
        state_q <= StWaitMagic;
      end else begin
        unique case (state_q)
          StWaitMagic: begin
            if (rx_valid && rx_byte == Magic) begin
              state_q    <= StLen0;
              error_q    <= 1'b0;
              word_idx_q <= '0;
              byte_idx_q <= '0;
              sum_q      <= '0;
            end else if (!error_q) begin
              // After a failed load the boot window is frozen: wait for a new image.
              if (boot_cnt_q == BootLast) begin
                state_q <= StRun;
              end else begin
                boot_cnt_q <= boot_cnt_q + 32'd1;
              end
            end
          end

          StLen0: begin
            if (rx_valid) begin
              n_words_q <= {8'h00, rx_byte};
              state_q   <= StLen1;
            end
          end

          StLen1: begin
            if (rx_valid) begin
              n_words_q <= n_next;
              if ({16'h0000, n_next} > MaxWords) begin
                error_q <= 1'b1;
                state_q <= StWaitMagic;
              end else if (n_next == 16'd0) begin
                state_q <= StCsum;
              end else begin
                state_q <= StData;
              end
            end
          end

          StData: begin
            if (rx_valid) begin
              word_q     <= word_next;
              sum_q      <= sum_q + rx_byte;
              byte_idx_q <= byte_idx_q + 2'd1;
              if (byte_idx_q == 2'd3) begin
                // Write registers are loaded here so the write cycle is the next one and
                // a byte arriving in it cannot disturb the word being written.
                wmask_q    <= 4'b1111;
                addr_q     <= BASE_ADDR + {14'b0, word_idx_q, 2'b00};
                wdata_q    <= word_next;
                word_idx_q <= word_idx_q + 16'd1;
                if (word_idx_q + 16'd1 == n_words_q) begin
                  state_q <= StCsum;
                end
              end
            end
          end

          StCsum: begin
            if (rx_valid) begin
              if (rx_byte == sum_q) begin
                state_q <= StRun;
              end else begin
                error_q <= 1'b1;
                state_q <= StWaitMagic;
              end
            end
          end

          StRun: begin
            // Terminal until reset; UART traffic is ignored.
          end

          default: begin
            state_q <= StWaitMagic;
          end
        endcase
      end
    end
  end

  // RAM port mux: the CPU owns it only in RUN; otherwise loader values are held.
  always_comb begin
    ram_addr  = addr_q;
    ram_rstrb = 1'b0;
    ram_wdata = wdata_q;
    ram_wmask = wmask_q;
    if (state_q == StRun) begin
      ram_addr  = cpu_mem_addr;
      ram_rstrb = cpu_mem_rstrb;
      ram_wdata = cpu_mem_wdata;
      ram_wmask = cpu_mem_wmask;
    end
  end

  assign cpu_resetn = cpu_resetn_q;
  assign busy       = in_frame;
  assign error      = error_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader. Expected RAM writes and checksums are
// computed from the frame contents with plain arithmetic; loader writes are captured by
// a monitor while the CPU is held in reset.
module tb_uart_boot_loader;

  localparam int unsigned BW   = 100;
  localparam int unsigned TO   = 50;
  localparam int unsigned MW   = 1536;
  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic [31:0] cpu_mem_addr;
  logic        cpu_mem_rstrb;
  logic [31:0] cpu_mem_wdata;
  logic [3:0]  cpu_mem_wmask;
  logic [31:0] ram_addr;
  logic        ram_rstrb;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wmask;
  logic        cpu_resetn;
  logic        busy;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pay[$];
  logic [67:0] wr_q[$];

  uart_boot_loader #(
    .BASE_ADDR      (BASE),
    .MAX_WORDS      (MW),
    .BOOT_WAIT      (BW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_byte       (rx_byte),
    .cpu_mem_addr  (cpu_mem_addr),
    .cpu_mem_rstrb (cpu_mem_rstrb),
    .cpu_mem_wdata (cpu_mem_wdata),
    .cpu_mem_wmask (cpu_mem_wmask),
    .ram_addr      (ram_addr),
    .ram_rstrb     (ram_rstrb),
    .ram_wdata     (ram_wdata),
    .ram_wmask     (ram_wmask),
    .cpu_resetn    (cpu_resetn),
    .busy          (busy),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Loader writes: every cycle with a nonzero mask while the CPU is held in reset.
  always @(negedge clk) begin
    if (cpu_resetn === 1'b0 && ram_wmask !== 4'b0000) begin
      wr_q.push_back({ram_addr, ram_wdata, ram_wmask});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at a negedge after 'gap' idle cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_byte  = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset;
    reset         = 1'b1;
    rx_valid      = 1'b0;
    cpu_mem_addr  = '0;
    cpu_mem_rstrb = 1'b0;
    cpu_mem_wdata = '0;
    cpu_mem_wmask = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_q.delete();
  endtask

  // Sends the frame held in 'pay' and checks the resulting writes and status.
  task automatic load_scenario(input string name, input bit corrupt, input logic [7:0] bad_csum,
                               input int max_gap);
    int          n;
    logic [7:0]  sum;
    logic [7:0]  csum;
    bit          ok;
    logic [67:0] exp;
    n   = pay.size() / 4;
    sum = 8'h00;
    foreach (pay[i]) sum = sum + pay[i];
    csum = corrupt ? bad_csum : sum;
    ok   = (csum == sum);
    wr_q.delete();
    send_byte(8'hA5, int'($urandom_range(0, max_gap)));
    send_byte(8'(n), int'($urandom_range(0, max_gap)));
    send_byte(8'(n >> 8), int'($urandom_range(0, max_gap)));
    foreach (pay[i]) send_byte(pay[i], int'($urandom_range(0, max_gap)));
    send_byte(csum, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d expected %0d", name, wr_q.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        exp = {BASE + 32'(4 * i), pay[4*i+3], pay[4*i+2], pay[4*i+1], pay[4*i], 4'hF};
        checks++;
        if (wr_q[i] !== exp) begin
          errors++;
          $display("FAIL %s write[%0d]: got %h expected %h", name, i, wr_q[i], exp);
        end
      end
    end
    checks++;
    if (error !== !ok) begin
      errors++;
      $display("FAIL %s error: got %b expected %b", name, error, !ok);
    end
    checks++;
    if (cpu_resetn !== ok) begin
      errors++;
      $display("FAIL %s cpu_resetn: got %b expected %b", name, cpu_resetn, ok);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy: got %b expected 0", name, busy);
    end
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    rx_valid      = 1'b1;
    rx_byte       = 8'hA5;
    cpu_mem_addr  = 32'hDEAD_BEEF;
    cpu_mem_rstrb = 1'b1;
    cpu_mem_wdata = 32'h1234_5678;
    cpu_mem_wmask = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cpu_resetn, busy, error, ram_wmask, ram_rstrb} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: got cpu_resetn=%b busy=%b error=%b wmask=%h rstrb=%b expected all 0",
               cpu_resetn, busy, error, ram_wmask, ram_rstrb);
    end
    @(negedge clk);
    reset         = 1'b0;
    rx_valid      = 1'b0;
    cpu_mem_addr  = '0;
    cpu_mem_rstrb = 1'b0;
    cpu_mem_wdata = '0;
    cpu_mem_wmask = '0;
    wr_q.delete();
  endtask

  // Must immediately follow the release of reset: edges are counted from there.
  task automatic test_autoboot;
    bit          early;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        r;
    early = 1'b0;
    for (int k = 1; k <= int'(BW) + 1; k++) begin
      @(posedge clk);
      #1;
      if (k <= int'(BW) && cpu_resetn !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early) begin
      errors++;
      $display("FAIL autoboot_early: got cpu_resetn=1 before edge %0d expected 0", BW + 1);
    end
    checks++;
    if (cpu_resetn !== 1'b1) begin
      errors++;
      $display("FAIL autoboot_release: got cpu_resetn=%b expected 1", cpu_resetn);
    end
    checks++;
    if (error !== 1'b0 || busy !== 1'b0 || wr_q.size() != 0) begin
      errors++;
      $display("FAIL autoboot_status: got error=%b busy=%b writes=%0d expected 0 0 0",
               error, busy, wr_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = $urandom;
      d = $urandom;
      m = 4'($urandom);
      r = 1'($urandom);
      cpu_mem_addr  = a;
      cpu_mem_wdata = d;
      cpu_mem_wmask = m;
      cpu_mem_rstrb = r;
      #1;
      checks++;
      if ({ram_addr, ram_wdata, ram_wmask, ram_rstrb} !== {a, d, m, r}) begin
        errors++;
        $display("FAIL autoboot_mirror: got %h %h %h %b expected %h %h %h %b",
                 ram_addr, ram_wdata, ram_wmask, ram_rstrb, a, d, m, r);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    logic [7:0] fixed [8];
    fixed = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    do_reset();
    pay.delete();
    foreach (fixed[i]) pay.push_back(fixed[i]);
    load_scenario("good_frame", 1'b0, 8'h00, 0);
  endtask

  task automatic test_bad_checksum;
    bit booted;
    do_reset();
    // pay still holds the fixed two-word image (sum 8'h64)
    load_scenario("bad_csum", 1'b1, 8'h00, 1);
    booted = 1'b0;
    repeat (10 * BW) begin
      @(negedge clk);
      if (cpu_resetn !== 1'b0) booted = 1'b1;
    end
    checks++;
    if (booted || error !== 1'b1) begin
      errors++;
      $display("FAIL bad_csum_no_autoboot: got booted=%b error=%b expected 0 1", booted, error);
    end
    load_scenario("recover", 1'b0, 8'h00, 1);
  endtask

  task automatic test_oversize;
    int n;
    for (int t = 0; t < 2; t++) begin
      n = (t == 0) ? int'(MW) + 1 : int'($urandom_range(MW + 1, 65535));
      do_reset();
      send_byte(8'hA5, 0);
      send_byte(8'(n), 0);
      send_byte(8'(n >> 8), 0);
      repeat (2) @(negedge clk);
      checks++;
      if (error !== 1'b1 || busy !== 1'b0 || cpu_resetn !== 1'b0 || wr_q.size() != 0) begin
        errors++;
        $display("FAIL oversize n=%0d: got error=%b busy=%b cpu_resetn=%b writes=%0d expected 1 0 0 0",
                 n, error, busy, cpu_resetn, wr_q.size());
      end
    end
    // Exactly MAX_WORDS is accepted.
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'(MW), 0);
    send_byte(8'(MW >> 8), 0);
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL max_words_accepted: got busy=%b error=%b expected 1 0", busy, error);
    end
  endtask

  task automatic test_timeout;
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    repeat (TO - 2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got busy=%b error=%b expected 1 0", busy, error);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || error !== 1'b1 || wr_q.size() != 0 || cpu_resetn !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort: got busy=%b error=%b writes=%0d cpu_resetn=%b expected 0 1 0 0",
               busy, error, wr_q.size(), cpu_resetn);
    end
  endtask

  task automatic test_zero_length_run;
    logic [31:0] d;
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() != 0 || cpu_resetn !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL zero_len: got writes=%0d cpu_resetn=%b error=%b expected 0 1 0",
               wr_q.size(), cpu_resetn, error);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h11, 2);
    checks++;
    if (busy !== 1'b0 || cpu_resetn !== 1'b1 || ram_wmask !== 4'b0000) begin
      errors++;
      $display("FAIL run_ignores_rx: got busy=%b cpu_resetn=%b wmask=%h expected 0 1 0",
               busy, cpu_resetn, ram_wmask);
    end
    d = $urandom;
    cpu_mem_addr  = 32'd8;
    cpu_mem_wdata = d;
    cpu_mem_wmask = 4'b0011;
    cpu_mem_rstrb = 1'b0;
    #1;
    checks++;
    if ({ram_addr, ram_wdata, ram_wmask, ram_rstrb} !== {32'd8, d, 4'b0011, 1'b0}) begin
      errors++;
      $display("FAIL run_cpu_write: got %h %h %h %b expected %h %h 3 0",
               ram_addr, ram_wdata, ram_wmask, ram_rstrb, 32'd8, d);
    end
    @(negedge clk);
  endtask

  task automatic test_random_frames;
    int         n;
    bit         corrupt;
    logic [7:0] sum;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      pay.delete();
      n   = int'($urandom_range(1, 8));
      sum = 8'h00;
      for (int i = 0; i < 4 * n; i++) begin
        pay.push_back(8'($urandom));
        sum = sum + pay[i];
      end
      corrupt = ($urandom_range(0, 2) == 0);
      load_scenario((it % 2 == 0) ? "back_to_back" : "random_gaps", corrupt,
                    sum + 8'($urandom_range(1, 255)), (it % 2 == 0) ? 0 : 3);
    end
  endtask

  initial begin
    reset         = 1'b1;
    rx_valid      = 1'b0;
    rx_byte       = '0;
    cpu_mem_addr  = '0;
    cpu_mem_rstrb = 1'b0;
    cpu_mem_wdata = '0;
    cpu_mem_wmask = '0;
    test_reset();
    test_autoboot();
    test_good_frame();
    test_bad_checksum();
    test_oversize();
    test_timeout();
    test_zero_length_run();
    test_random_frames();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
Boot sequencer and RAM port arbiter for the SoC. After reset it holds the CPU in reset and owns the RAM write port. It accepts a framed program image from the UART receiver and writes it word by word into RAM, then releases the CPU and hands the RAM port to it permanently. If no image arrives within a boot window, it releases the CPU to run the preloaded RAM contents.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of the first loaded word (word-aligned).
MAX_WORDS, 1536, largest accepted word count (RAM size in words).
BOOT_WAIT, 27_000_000, cycles to wait for the magic byte after reset before autoboot.
TIMEOUT_CYCLES, 2_700_000, maximum gap between bytes inside a frame.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_valid  in  1  one-cycle pulse: rx_byte is valid.
rx_byte  in  8  received UART byte.
cpu_mem_addr  in  32  CPU address.
cpu_mem_rstrb  in  1  CPU read strobe.
cpu_mem_wdata  in  32  CPU write data.
cpu_mem_wmask  in  4  CPU write byte mask.
ram_addr  out  32  address to RAM.
ram_rstrb  out  1  read strobe to RAM.
ram_wdata  out  32  write data to RAM.
ram_wmask  out  4  write byte mask to RAM.
cpu_resetn  out  1  active-low CPU reset.
busy  out  1  high while in LEN0/LEN1/DATA/CSUM.
error  out  1  sticky load error flag.

Behaviour:
- Frame format:
  - Magic byte 8'hA5.
  - N_lo, N_hi: 16-bit word count, little-endian.
  - 4N payload bytes; each word is little-endian (first byte lands in [7:0]).
  - CSUM byte: 8-bit sum mod 256 of all payload bytes.
- States:
  - WAIT_MAGIC: on rx_valid with 8'hA5, go to LEN0.
  - LEN0, LEN1: capture N.
  - DATA: receive payload bytes.
  - CSUM: compare checksum.
  - RUN: terminal until reset.
- Reset:
  - state=WAIT_MAGIC, cpu_resetn=0, busy=0, error=0, ram_wmask=0, ram_rstrb=0, word index=0, byte index=0, sum=0, boot counter=0.
- WAIT_MAGIC:
  - Boot counter increments each cycle while error=0.
  - Counter reaches BOOT_WAIT-1 with no magic: go to RUN.
  - If error=1, no autoboot; wait indefinitely for magic.
  - Non-magic bytes are ignored.
  - Magic byte clears error, word index, byte index and sum.
- LEN1, after capturing N:
  - N > MAX_WORDS: set error, go to WAIT_MAGIC.
  - N == 0: go to CSUM.
  - Otherwise go to DATA.
- DATA:
  - Each byte is shifted into the word assembly register and added to sum.
  - On the 4th byte of a word: in the next cycle, drive ram_wmask=4'b1111, ram_addr=BASE_ADDR+4*word_index, ram_wdata=assembled word, for exactly one cycle. Then word_index increments.
  - After word N-1 is written, go to CSUM.
- CSUM:
  - Byte == sum: go to RUN.
  - Byte != sum: set error, go to WAIT_MAGIC.
- Inter-byte timeout: in LEN0/LEN1/DATA/CSUM, a gap counter resets on every rx_valid. If it reaches TIMEOUT_CYCLES, set error and go to WAIT_MAGIC. A partially written image stays in RAM.
- RUN:
  - cpu_resetn=1 registered, asserted in the first cycle after entering RUN.
  - ram_* driven combinationally from cpu_mem_*.
  - rx bytes are ignored, including 8'hA5.
- Outside RUN:
  - CPU inputs are ignored.
  - ram_rstrb=0.
  - ram_wmask=0 except during write cycles.
  - ram_addr/ram_wdata hold their last loader values.
- Simultaneous events: an rx_valid in the write cycle is accepted normally; the write uses the previously assembled word. rx_valid in the same cycle as timeout expiry: the timeout wins.
- reset mid-frame aborts immediately. RAM words already written are not restored.
- busy = state in {LEN0, LEN1, DATA, CSUM}.

Test Plan:
1. Reset, no rx for BOOT_WAIT (bench uses 100) cycles -> cpu_resetn rises at cycle 100+1; ram_* then mirror cpu_mem_*; error=0.
2. Send A5 02 00, then 11 22 33 44 55 66 77 88, then CSUM 8'h64 -> writes 32'h44332211 at addr 0 and 32'h88776655 at addr 4, one cycle each; cpu_resetn=1; error=0.
3. Same frame with CSUM 8'h00 -> both words written, error=1, cpu_resetn stays 0, no autoboot after 10×BOOT_WAIT. A following valid frame clears error and boots.
4. A5 01 06 (N=1537) -> error=1, back in WAIT_MAGIC, no RAM writes.
5. A5 01 00 AA then silence for TIMEOUT_CYCLES (bench 50) -> error=1, busy=0, no write.
6. A5 00 00 00 -> zero-length frame: no writes, cpu_resetn=1. Then inject A5 while in RUN -> ignored; CPU writes wmask 4'b0011 to addr 8 appear on ram_* same cycle.
